// File: rtl/alu_op_responder.sv
// Registered valid/ready front end around a 16-bit 74181/74182 ALU.
// One request per cycle is captured into S1, evaluated, and queued in a small response FIFO.

module alu_181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sel,
  input  logic       mode,
  input  logic       cn_n,
  output logic [3:0] f,
  output logic       g_n,
  output logic       p_n
);

  logic [3:0] u;
  logic [3:0] v;
  logic [4:0] c;

  // u/v are the two addends the select lines form; v is always a subset of u
  always_comb begin
    u = a | (b & {4{sel[0]}}) | (~b & {4{sel[1]}});
    v = (a & ~b & {4{sel[2]}}) | (a & b & {4{sel[3]}});
    c = '0;
    c[0] = ~cn_n;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = v[i] | (u[i] & c[i]);
    end
    f   = mode ? ~(u ^ v) : (u ^ v ^ c[3:0]);
    g_n = ~(v[3] | (u[3] & v[2]) | (u[3] & u[2] & v[1]) | (u[3] & u[2] & u[1] & v[0]));
    p_n = ~(&u);
  end

endmodule

module alu_182 (
  input  logic [3:0] g_n,
  input  logic [3:0] p_n,
  input  logic       cn_n,
  output logic       cnx_n,
  output logic       cny_n,
  output logic       cnz_n,
  output logic       gy_n,
  output logic       px_n
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c0;

  always_comb begin
    g  = ~g_n;
    p  = ~p_n;
    c0 = ~cn_n;
    cnx_n = ~(g[0] | (p[0] & c0));
    cny_n = ~(g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0));
    cnz_n = ~(g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0));
    gy_n  = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
    px_n  = ~(&p);
  end

endmodule

module top_alu_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        mode,
  input  logic [3:0]  sel,
  input  logic        cin,
  output logic [15:0] result,
  output logic        cout,
  output logic        ngo,
  output logic        nbo
);

  logic [3:0] slice_cn_n;
  logic [3:0] slice_g_n;
  logic [3:0] slice_p_n;
  logic       cnx_n;
  logic       cny_n;
  logic       cnz_n;

  assign slice_cn_n = {cnz_n, cny_n, cnx_n, cin};

  for (genvar i = 0; i < 4; i++) begin : g_slice
    alu_181 u_slice (
      .a    (a[4*i +: 4]),
      .b    (b[4*i +: 4]),
      .sel  (sel),
      .mode (mode),
      .cn_n (slice_cn_n[i]),
      .f    (result[4*i +: 4]),
      .g_n  (slice_g_n[i]),
      .p_n  (slice_p_n[i])
    );
  end

  alu_182 u_lookahead (
    .g_n   (slice_g_n),
    .p_n   (slice_p_n),
    .cn_n  (cin),
    .cnx_n (cnx_n),
    .cny_n (cny_n),
    .cnz_n (cnz_n),
    .gy_n  (ngo),
    .px_n  (nbo)
  );

  // Active-low carry out of the whole word: not (G or P and carry-in)
  assign cout = ngo & (nbo | cin);

endmodule

module alu_op_responder #(
  parameter int TAG_W     = 4,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic             req_mode,
  input  logic [3:0]       req_sel,
  input  logic             req_cin,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic             rsp_cout,
  output logic             rsp_ngo,
  output logic             rsp_nbo,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] ops_done,
  output logic             busy
);

  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_FW = $clog2(OUT_DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(OUT_DEPTH - 1);
  localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(OUT_DEPTH);

  typedef struct packed {
    logic [15:0]      result;
    logic             cout;
    logic             ngo;
    logic             nbo;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  // Handshake rule: a transfer happens on a rising edge where valid && ready.
  // The requester holds req_* stable while req_valid && !req_ready; the block
  // holds rsp_* stable while rsp_valid && !rsp_ready. req_ready never looks at rsp_ready.

  logic             s1_valid;
  logic [15:0]      s1_a;
  logic [15:0]      s1_b;
  logic             s1_mode;
  logic [3:0]       s1_sel;
  logic             s1_cin;
  logic [TAG_W-1:0] s1_tag;

  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_ngo;
  logic        alu_nbo;
  rsp_t        alu_entry;

  rsp_t              fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_FW-1:0] fifo_count;

  logic fifo_full;
  logic accept;
  logic push;
  logic pop;
  rsp_t head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full = (fifo_count == FULL_CNT);
  assign push      = s1_valid && !fifo_full;
  assign req_ready = !s1_valid || !fifo_full;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = s1_valid || (fifo_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= 1'b0;
      s1_sel   <= '0;
      s1_cin   <= 1'b0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a;
      s1_b     <= req_b;
      s1_mode  <= req_mode;
      s1_sel   <= req_sel;
      s1_cin   <= req_cin;
      s1_tag   <= req_tag;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  top_alu_16 u_alu (
    .a      (s1_a),
    .b      (s1_b),
    .mode   (s1_mode),
    .sel    (s1_sel),
    .cin    (s1_cin),
    .result (alu_result),
    .cout   (alu_cout),
    .ngo    (alu_ngo),
    .nbo    (alu_nbo)
  );

  always_comb begin
    alu_entry        = '0;
    alu_entry.result = alu_result;
    alu_entry.cout   = alu_cout;
    alu_entry.ngo    = alu_ngo;
    alu_entry.nbo    = alu_nbo;
    alu_entry.zero   = (alu_result == 16'h0000);
    alu_entry.tag    = s1_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= alu_entry;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_done <= '0;
    end else if (pop) begin
      ops_done <= ops_done + 1'b1;
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign rsp_result = head.result;
  assign rsp_cout   = head.cout;
  assign rsp_ngo    = head.ngo;
  assign rsp_nbo    = head.nbo;
  assign rsp_zero   = head.zero;
  assign rsp_tag    = head.tag;

  req_hold_a: assert property (@(posedge clk) disable iff (reset)
    (req_valid && !req_ready) |=>
      (req_valid && $stable({req_a, req_b, req_mode, req_sel, req_cin, req_tag})));

  fifo_bound_a: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= FULL_CNT);

endmodule
